// File: rtl/pulse_gray_pkg.sv
// ============================================================================
// Module      : pulse_gray_pkg
// Description : Shared types and helpers for the Gray-coded pulse counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_gray_pkg;

    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned MAX_WIDTH    = 16;
    localparam int unsigned INC_MAX_W    = 5;

    typedef enum logic [1:0] {
        UP_WRAP = 2'b00,
        UP_SAT  = 2'b01,
        DN_WRAP = 2'b10,
        DN_SAT  = 2'b11
    } count_mode_t;

    // Width needed to hold a per-cycle increment of 0..channels.
    function automatic int unsigned inc_width(input int unsigned channels);
        return $clog2(channels + 1);
    endfunction

    function automatic logic [INC_MAX_W-1:0] popcount(input logic [MAX_CHANNELS-1:0] v);
        logic [INC_MAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            n = n + INC_MAX_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_gray_counter_if.sv
// ============================================================================
// Module      : pulse_gray_counter_if
// Description : Control, pulse and result bundle of the Gray pulse counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_gray_counter_if #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WIDTH    = 8
);
    logic                enable;
    logic                clear;
    logic [1:0]          mode;
    logic [CHANNELS-1:0] chan_mask;
    logic [CHANNELS-1:0] pulse;
    logic [WIDTH-1:0]    gray_count;
    logic                wrap_flag;

    modport master (
        output enable, clear, mode, chan_mask, pulse,
        input  gray_count, wrap_flag
    );

    modport slave (
        input  enable, clear, mode, chan_mask, pulse,
        output gray_count, wrap_flag
    );
endinterface

`default_nettype wire

// File: rtl/pulse_edge_sync.sv
// ============================================================================
// Module      : pulse_edge_sync
// Description : One channel: optional synchroniser chain plus rising-edge
//               detector. Chain present only when PULSE_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_pulse,
    output logic      o_rise
);

`ifdef PULSE_SYNC_EN
    localparam int unsigned STAGES = SYNC_STAGES;
`else
    // Inputs are already synchronous; the depth parameter has no effect.
    localparam int unsigned STAGES = SYNC_STAGES * 0;
`endif

    logic w_sync_out;
    logic r_prev;

    generate
        if (STAGES > 0) begin : g_sync
            logic [STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= (r_sync << 1) | STAGES'(i_pulse);
                end
            end

            assign w_sync_out = r_sync[STAGES-1];
        end else begin : g_direct
            assign w_sync_out = i_pulse;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync_out;
        end
    end

    assign o_rise = w_sync_out & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pulse_gray_counter.sv
// ============================================================================
// Module      : pulse_gray_counter
// Description : Multi-channel pulse counter, up/down wrap/saturate, Gray
//               output with sticky wrap flag. Honours PULSE_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_gray_counter
    import pulse_gray_pkg::*;
#(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    pulse_gray_counter_if.slave  bus
);

    localparam int unsigned INC_W = inc_width(CHANNELS);

    logic [CHANNELS-1:0] w_rise;
    logic [INC_W-1:0]    w_inc;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    w_count_next;
    logic [WIDTH-1:0]    r_gray;
    logic                r_wrap;
    logic                w_wrap_next;
    count_mode_t         w_mode;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            pulse_edge_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_edge (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_pulse (bus.pulse[i]),
                .o_rise  (w_rise[i])
            );
        end
    endgenerate

    assign w_inc  = INC_W'(popcount(16'(w_rise & bus.chan_mask)));
    assign w_mode = count_mode_t'(bus.mode);

    // One extra bit so the top bit is the carry (up) or borrow (down).
    assign w_sum  = {1'b0, r_count} + (WIDTH+1)'(w_inc);
    assign w_diff = {1'b0, r_count} - (WIDTH+1)'(w_inc);

    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = r_wrap;
        if (bus.clear) begin
            w_count_next = '0;
            w_wrap_next  = 1'b0;
        end else if (bus.enable) begin
            case (w_mode)
                UP_WRAP: begin
                    w_count_next = w_sum[WIDTH-1:0];
                    w_wrap_next  = r_wrap | w_sum[WIDTH];
                end
                UP_SAT: begin
                    w_count_next = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
                    w_wrap_next  = r_wrap | w_sum[WIDTH];
                end
                DN_WRAP: begin
                    w_count_next = w_diff[WIDTH-1:0];
                    w_wrap_next  = r_wrap | w_diff[WIDTH];
                end
                DN_SAT: begin
                    w_count_next = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
                    w_wrap_next  = r_wrap | w_diff[WIDTH];
                end
                default: begin
                    w_count_next = r_count;
                    w_wrap_next  = r_wrap;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_gray  <= WIDTH'(bin2gray(16'(w_count_next)));
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.gray_count = r_gray;
    assign bus.wrap_flag  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_pulse_gray_counter.sv
// ============================================================================
// Module      : tb_pulse_gray_counter
// Description : Self-checking bench: vector table plus scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_gray_counter;

    localparam int unsigned CHANNELS    = 8;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef PULSE_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [1:0] mode;
        logic [7:0] mask;
        logic [7:0] pat;
        logic       en;
        logic       clr;
        logic [7:0] gray;
        logic       wrap;
    } vec_t;

    typedef struct {
        logic [7:0] gray;
        logic       wrap;
        int         id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[$];
    exp_t sb[$];

    pulse_gray_counter_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

    pulse_gray_counter #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_gray(input int unsigned b);
        logic [7:0] x;
        x = b[7:0];
        return x ^ (x >> 1);
    endfunction

    function automatic void add_vec(input logic [1:0] mode, input logic [7:0] mask,
                                    input logic [7:0] pat, input logic en, input logic clr,
                                    input int unsigned count, input logic wrap);
        vec_t v;
        v.mode = mode; v.mask = mask; v.pat = pat; v.en = en; v.clr = clr;
        v.gray = to_gray(count);
        v.wrap = wrap;
        vecs.push_back(v);
    endfunction

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty: got nothing, expected an entry");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.gray_count !== e.gray) begin
                n_fail++;
                $display("FAIL step%0d gray_count: got %h, expected %h", e.id, bus.gray_count, e.gray);
            end
            n_cmp++;
            if (bus.wrap_flag !== e.wrap) begin
                n_fail++;
                $display("FAIL step%0d wrap_flag: got %b, expected %b", e.id, bus.wrap_flag, e.wrap);
            end
        end
    endtask

    // Pulse high one cycle, then low until the edge has reached the counter.
    task automatic apply(input vec_t v, input int id);
        @(negedge clk);
        bus.mode      = v.mode;
        bus.chan_mask = v.mask;
        bus.enable    = v.en;
        bus.clear     = v.clr;
        bus.pulse     = v.pat;
        sb.push_back('{gray: v.gray, wrap: v.wrap, id: id});
        @(negedge clk);
        bus.pulse = '0;
        repeat (LAT + 1) @(negedge clk);
        check_pop();
    endtask

    function automatic void add_clear();
        add_vec(2'b00, 8'h01, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    endfunction

    function automatic void add_climb_248();
        for (int i = 1; i <= 31; i++) add_vec(2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0, 8 * i, 1'b0);
    endfunction

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_cmp = 0;
        n_fail = 0;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.mode = 2'b00;
        bus.chan_mask = 8'h01;
        bus.pulse = '0;

        // Basic counting and multi-channel edges
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 1, 1'b0);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 2, 1'b0);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 3, 1'b0);
        add_clear();
        add_vec(2'b00, 8'h0F, 8'hFF, 1'b1, 1'b0, 4, 1'b0);
        add_vec(2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0, 12, 1'b0);
        add_vec(2'b10, 8'h0F, 8'h0F, 1'b1, 1'b0, 8, 1'b0);
        add_vec(2'b10, 8'hFF, 8'h00, 1'b1, 1'b0, 8, 1'b0);
        // Up-wrap across 255
        add_clear();
        add_climb_248();
        add_vec(2'b00, 8'h3F, 8'h3F, 1'b1, 1'b0, 254, 1'b0);
        add_vec(2'b01, 8'h01, 8'h01, 1'b1, 1'b0, 255, 1'b0);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 0, 1'b1);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 1, 1'b1);
        // Up-saturate clamp, and an edge while already at the limit
        add_clear();
        add_climb_248();
        add_vec(2'b00, 8'h3F, 8'h3F, 1'b1, 1'b0, 254, 1'b0);
        add_vec(2'b01, 8'h07, 8'h07, 1'b1, 1'b0, 255, 1'b1);
        add_vec(2'b01, 8'h01, 8'h01, 1'b1, 1'b0, 255, 1'b1);
        // Down-saturate
        add_clear();
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 1, 1'b0);
        add_vec(2'b11, 8'h07, 8'h07, 1'b1, 1'b0, 0, 1'b1);
        add_clear();
        add_vec(2'b11, 8'h01, 8'h01, 1'b1, 1'b0, 0, 1'b1);
        add_clear();
        add_vec(2'b00, 8'h0F, 8'h0F, 1'b1, 1'b0, 4, 1'b0);
        add_vec(2'b11, 8'h03, 8'h03, 1'b1, 1'b0, 2, 1'b0);
        // Clear coinciding with an edge
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b1, 0, 1'b0);
        // Enable low discards edges; no burst on re-enable
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 1, 1'b0);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 2, 1'b0);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 3, 1'b0);
        for (int i = 0; i < 5; i++) add_vec(2'b00, 8'h01, 8'h01, 1'b0, 1'b0, 3, 1'b0);
        add_vec(2'b00, 8'h01, 8'h00, 1'b1, 1'b0, 3, 1'b0);
        add_vec(2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 4, 1'b0);
        // Down-wrap below zero
        add_clear();
        add_vec(2'b10, 8'h01, 8'h01, 1'b1, 1'b0, 255, 1'b1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{gray: 8'h00, wrap: 1'b0, id: -1});
        check_pop();

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{gray: 8'h00, wrap: 1'b0, id: 1000});
        check_pop();

        // Pulse held high across reset release counts exactly once
        bus.mode = 2'b00;
        bus.chan_mask = 8'h01;
        bus.enable = 1'b1;
        bus.clear = 1'b0;
        bus.pulse = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        sb.push_back('{gray: 8'h01, wrap: 1'b0, id: 1001});
        check_pop();
        repeat (4) @(negedge clk);
        sb.push_back('{gray: 8'h01, wrap: 1'b0, id: 1002});
        check_pop();
        bus.pulse = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_gray_counter.md
# pulse_gray_counter

Parametrised multi-channel pulse counter with Gray-coded output. It is the next generation of the single-channel PULSE counter used under the TinyTapeout top wrapper.

- Synchronises up to CHANNELS asynchronous pulse inputs and detects rising edges per channel.
- Accumulates the masked edge count each cycle into a WIDTH-bit counter.
- Counter supports up/down and wrap/saturate modes.
- Presents the count Gray-coded with a sticky wrap flag.

## Interface
Parameters:
- CHANNELS, 8: number of pulse input channels (1..16)
- WIDTH, 8: counter and output width (4..16)
- SYNC_STAGES, 2: synchroniser depth per channel (2..3)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  count enable; edges detected while low are discarded, not deferred
- clear  in  1  synchronous clear of counter and wrap_flag
- mode  in  2  00 up-wrap, 01 up-saturate, 10 down-wrap, 11 down-saturate
- chan_mask  in  CHANNELS  1 = channel contributes to the count
- pulse  in  CHANNELS  raw asynchronous pulse inputs
- gray_count  out  WIDTH  registered Gray code of the internal binary count
- wrap_flag  out  1  sticky; set on wrap or on saturation clamp

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then an edge register.
  - edge = sync_out & ~prev.
  - The synchroniser and edge register always run, regardless of enable.
- inc = popcount(edge & chan_mask), width clog2(CHANNELS+1).
- Priority per cycle: reset > clear > count.
  - clear = 1: count and wrap_flag go to 0; edges in that cycle are dropped.
  - enable = 1, clear = 0: count_next is computed from mode.
    - Up-wrap: (count + inc) mod 2^WIDTH.
    - Down-wrap: (count − inc) mod 2^WIDTH.
    - Up-saturate: min(count + inc, 2^WIDTH−1).
    - Down-saturate: max(count − inc, 0).
  - enable = 0: count holds.
- Arithmetic is done at WIDTH+1 bits; the carry/borrow bit decides wrap and clamp.
- wrap_flag is set when any of the following happens:
  - wrap modes: the carry or borrow bit is set;
  - saturate modes: the true result lies outside [0, 2^WIDTH−1], including an edge arriving while already at the limit.
- wrap_flag is cleared only by clear or reset.
- gray_count <= bin2gray(count_next), registered in the same cycle as count.
  - A single-bit change is guaranteed only when inc ≤ 1.
- A mode or chan_mask change takes effect on the next cycle. The count value is untouched.
- Reset mid-operation clears all state immediately, without waiting for clk.

## Timing
- Reset values: gray_count = 0, wrap_flag = 0, synchroniser and edge registers = 0.
- Latency: pulse first sampled high at posedge k updates gray_count at posedge k+SYNC_STAGES.
- An input held high across reset release produces exactly one edge and is counted once.
- Minimum detectable pulse: high and low each for at least one clk period plus setup. Shorter pulses may be missed.
- Simultaneous edges on several channels in one cycle are all counted (inc up to CHANNELS).
- clear takes effect at the next posedge; outputs read 0 one cycle after clear is sampled.

## Configuration
- PULSE_SYNC_EN defined: the synchroniser chain is instantiated as described above.
- PULSE_SYNC_EN undefined: pulse feeds the edge register directly.
  - Inputs must be synchronous to clk.
  - SYNC_STAGES is ignored.
  - The count updates at the first posedge that samples pulse high (latency 0 stages).

## Structure
- Package pulse_gray_pkg:
  - count_mode_t enum (UP_WRAP, UP_SAT, DN_WRAP, DN_SAT);
  - bin2gray function;
  - popcount function;
  - INC_W localparam helper.
- Sub-module pulse_edge_sync: one channel's synchroniser and rising-edge detector, generated CHANNELS times.
  - The PULSE_SYNC_EN guard lives inside this sub-module.
- The top holds the popcount, mode arithmetic, count register, Gray register and wrap_flag.

## Test plan
Default parameters, PULSE_SYNC_EN defined.
- Reset with mode = 00, chan_mask = 0x01:
  - one pulse on ch0 → gray_count = 0x01 two posedges after sampling;
  - two more pulses → 0x02 (binary 3).
- Simultaneous edges: from 0, pulse = 0xFF in one cycle with chan_mask = 0x0F → count += 4, gray_count = 0x06, wrap_flag = 0.
- Wrap: up-wrap from binary 255 (gray 0x80), one edge → gray 0x00, wrap_flag = 1; the flag stays 1 through further edges until clear.
- Saturate:
  - up-sat at 254, three edges in one cycle → 255 (gray 0x80), wrap_flag = 1;
  - down-sat at 1, three edges → 0, wrap_flag = 1.
- clear asserted in the same cycle as an edge → count 0, wrap_flag 0.
- enable = 0 during 5 pulses, then enable = 1 → count unchanged, no burst on re-enable.
- Async reset:
  - rst_n low mid-run between clk edges → gray_count = 0 and wrap_flag = 0 before the next posedge;
  - pulse held high across release → count becomes exactly 1.
